// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module   : regfile_pkg
// Purpose  : Shared definitions for the integer register file and decode:
//            default geometry, register index type and the hardwired zero
//            register index.
// Revision : 1.0 - initial release
// ============================================================================
package regfile_pkg;

  localparam int DEFAULT_DATA_WIDTH = 64;
  localparam int DEFAULT_NUM_REGS   = 32;
  localparam int DEFAULT_IDX_W      = $clog2(DEFAULT_NUM_REGS);

  typedef logic [DEFAULT_IDX_W-1:0] reg_idx_t;

  // x0 reads as zero and never holds a reservation
  localparam reg_idx_t ZERO_REG = '0;

endpackage
`default_nettype wire

// File: rtl/rf_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : rf_scoreboard
// Purpose  : Pending-write tracking for the register file. One busy bit per
//            architectural register, set when a destination is issued and
//            cleared by write-back or flush. Also produces per-read-port busy
//            flags, the issue handshake and a registered busy count.
// Ports    : clk, reset      clock, synchronous active-high reset
//            rd_addr         packed read indices (NUM_RD x IDX_W)
//            wr_hit          one bit per register: valid write-back this cycle
//            issue_en/rd     destination reservation request
//            flush           drop all reservations
//            rd_busy         per read port: operand still pending
//            issue_ready     destination may be reserved this cycle
//            pending_cnt     number of busy registers
// Revision : 1.0 - initial release
// ============================================================================
module rf_scoreboard
  import regfile_pkg::*;
#(
  parameter int NUM_REGS = DEFAULT_NUM_REGS,
  parameter int NUM_RD   = 2,
  parameter int BYPASS   = 1,
  parameter int IDX_W    = $clog2(NUM_REGS)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_RD*IDX_W-1:0] rd_addr,
  input  logic [NUM_REGS-1:0]     wr_hit,
  input  logic                    issue_en,
  input  logic [IDX_W-1:0]        issue_rd,
  input  logic                    flush,
  output logic [NUM_RD-1:0]       rd_busy,
  output logic                    issue_ready,
  output logic [IDX_W:0]          pending_cnt
);

  logic [NUM_REGS-1:0] r_busy;
  logic [NUM_REGS-1:0] w_busy_nxt;
  logic [IDX_W:0]      r_cnt;
  logic [IDX_W:0]      w_cnt_nxt;

  // A busy destination becomes free in the same cycle its write-back lands
  // only when that write-back is forwarded.
  assign issue_ready = (issue_rd == '0) || !r_busy[issue_rd] ||
                       ((BYPASS != 0) && wr_hit[issue_rd]);

  always_comb begin
    // Clear first, then set: a new producer owns the register even when the
    // previous producer writes back in the same cycle.
    w_busy_nxt = r_busy & ~wr_hit;
    if (issue_en && issue_ready && (issue_rd != '0))
      w_busy_nxt[issue_rd] = 1'b1;
    if (flush)
      w_busy_nxt = '0;

    w_cnt_nxt = '0;
    for (int r = 0; r < NUM_REGS; r++)
      w_cnt_nxt = w_cnt_nxt + {{IDX_W{1'b0}}, w_busy_nxt[r]};
  end

  // The count is computed from the next busy vector so it always agrees
  // with the registered bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy <= '0;
      r_cnt  <= '0;
    end else begin
      r_busy <= w_busy_nxt;
      r_cnt  <= w_cnt_nxt;
    end
  end

  assign pending_cnt = r_cnt;

  generate
    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd_busy
      logic [IDX_W-1:0] w_ra;
      assign w_ra       = rd_addr[i*IDX_W +: IDX_W];
      // Bit 0 is never set, so x0 always reports not busy.
      assign rd_busy[i] = r_busy[w_ra] && !((BYPASS != 0) && wr_hit[w_ra]);
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/multiport_reg_file.sv
`default_nettype none
// ============================================================================
// Module   : multiport_reg_file
// Purpose  : Integer register file with NUM_RD combinational read ports,
//            NUM_WR write-back ports (highest port wins on collision),
//            optional write-to-read bypass and a pending-write scoreboard.
//            Register 0 is hardwired to zero.
// Ports    : clk, reset      clock, synchronous active-high reset
//            rd_addr/rd_data packed read indices / read data
//            rd_busy         per read port: operand still pending
//            wr_en/addr/data packed write-back ports
//            issue_en/rd     destination reservation, issue_ready handshake
//            flush           drop all reservations
//            pending_cnt     number of busy registers
// Revision : 1.0 - initial release
// ============================================================================
module multiport_reg_file
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int NUM_REGS   = DEFAULT_NUM_REGS,
  parameter int NUM_RD     = 2,
  parameter int NUM_WR     = 2,
  parameter int BYPASS     = 1,
  parameter int IDX_W      = $clog2(NUM_REGS)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_RD*IDX_W-1:0]      rd_addr,
  output logic [NUM_RD*DATA_WIDTH-1:0] rd_data,
  output logic [NUM_RD-1:0]            rd_busy,
  input  logic [NUM_WR-1:0]            wr_en,
  input  logic [NUM_WR*IDX_W-1:0]      wr_addr,
  input  logic [NUM_WR*DATA_WIDTH-1:0] wr_data,
  input  logic                         issue_en,
  input  logic [IDX_W-1:0]             issue_rd,
  output logic                         issue_ready,
  input  logic                         flush,
  output logic [IDX_W:0]               pending_cnt
);

  logic [DATA_WIDTH-1:0] r_regs   [NUM_REGS];
  logic [NUM_REGS-1:0]   w_wr_hit;
  logic [DATA_WIDTH-1:0] w_wr_val [NUM_REGS];

  // Per-register write arbitration. Ports are scanned in ascending order so
  // the highest-numbered port targeting a register supplies its data.
  always_comb begin
    w_wr_hit = '0;
    for (int r = 0; r < NUM_REGS; r++)
      w_wr_val[r] = '0;
    for (int j = 0; j < NUM_WR; j++) begin
      if (wr_en[j] && (wr_addr[j*IDX_W +: IDX_W] != '0)) begin
        w_wr_hit[wr_addr[j*IDX_W +: IDX_W]] = 1'b1;
        w_wr_val[wr_addr[j*IDX_W +: IDX_W]] = wr_data[j*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  generate
    for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
      if (r == 0) begin : g_zero
        assign r_regs[r] = '0;
      end else begin : g_store
        always_ff @(posedge clk) begin
          if (reset)
            r_regs[r] <= '0;
          else if (w_wr_hit[r])
            r_regs[r] <= w_wr_val[r];
        end
      end
    end
  endgenerate

  // x0 needs no special case here: its storage is zero and it never hits.
  generate
    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
      logic [IDX_W-1:0] w_ra;
      assign w_ra = rd_addr[i*IDX_W +: IDX_W];
      assign rd_data[i*DATA_WIDTH +: DATA_WIDTH] =
          ((BYPASS != 0) && w_wr_hit[w_ra]) ? w_wr_val[w_ra] : r_regs[w_ra];
    end
  endgenerate

  rf_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .NUM_RD   (NUM_RD),
    .BYPASS   (BYPASS),
    .IDX_W    (IDX_W)
  ) u_scoreboard (
    .clk         (clk),
    .reset       (reset),
    .rd_addr     (rd_addr),
    .wr_hit      (w_wr_hit),
    .issue_en    (issue_en),
    .issue_rd    (issue_rd),
    .flush       (flush),
    .rd_busy     (rd_busy),
    .issue_ready (issue_ready),
    .pending_cnt (pending_cnt)
  );

endmodule
`default_nettype wire
